// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with ghost blanking and frame-synchronous data commit.
// Latency: outputs registered, one cycle behind the (divcount, idx, shown) scan state.
// Backpressure: none; load is always accepted, and the last load before a frame wrap wins.
module seg7_scan_driver #(
   parameter int NDIGITS  = 4,
   parameter int SCANDIV  = 16,
   parameter int BLANKCYC = 2
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   value,
   input  logic [NDIGITS-1:0]     dpin,
   input  logic [NDIGITS-1:0]     blankmask,
   output logic [NDIGITS-1:0]     digitsel_n,
   output logic [6:0]             segments_n,
   output logic                   dp_n,
   output logic                   pending,
   output logic                   framedone
);

   localparam int DW = $clog2(SCANDIV);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam logic [DW-1:0] DLAST    = DW'(SCANDIV - 1);
   localparam logic [IW-1:0] ILAST    = IW'(NDIGITS - 1);
   localparam logic [DW-1:0] BLANKLIM = DW'(BLANKCYC);

   logic [DW-1:0]          divcount;
   logic [IW-1:0]          idx;
   logic [4*NDIGITS-1:0]   stagedval, shownval;
   logic [NDIGITS-1:0]     stageddp, showndp;
   logic [NDIGITS-1:0]     stagedblank, shownblank;
   logic                   wrap;
   logic [3:0]             nib;
   logic                   curdp, curblank;
   logic [NDIGITS-1:0]     nxtsel;
   logic [6:0]             nxtseg;
   logic                   nxtdp;

   // hex nibble to segment pattern, gfedcba, 1 = lit
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign wrap = (idx == ILAST) && (divcount == DLAST);

   // slot timer and digit index; framedone marks the cycle right after a frame wrap
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         divcount  <= '0;
         idx       <= '0;
         framedone <= 1'b0;
      end else begin
         framedone <= wrap;
         if (divcount == DLAST) begin
            divcount <= '0;
            idx      <= (idx == ILAST) ? '0 : idx + 1'b1;
         end else begin
            divcount <= divcount + 1'b1;
         end
      end
   end

   // staging and frame-boundary commit; a load on the wrap edge commits the older data first
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         stagedval   <= '0;
         stageddp    <= '0;
         stagedblank <= '0;
         shownval    <= '0;
         showndp     <= '0;
         shownblank  <= '0;
         pending     <= 1'b0;
      end else begin
         if (wrap && pending) begin
            shownval   <= stagedval;
            showndp    <= stageddp;
            shownblank <= stagedblank;
         end
         if (load) begin
            stagedval   <= value;
            stageddp    <= dpin;
            stagedblank <= blankmask;
            pending     <= 1'b1;
         end else if (wrap) begin
            pending <= 1'b0;
         end
      end
   end

   // next display pattern from the current slot; blanking covers slot start and masked digits
   always_comb begin
      nib      = 4'h0;
      curdp    = 1'b0;
      curblank = 1'b0;
      nxtsel   = '1;
      nxtseg   = 7'h7F;
      nxtdp    = 1'b1;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx == IW'(i)) begin
            nib      = shownval[4*i +: 4];
            curdp    = showndp[i];
            curblank = shownblank[i];
         end
      end
      if (!(divcount < BLANKLIM) && !curblank) begin
         for (int i = 0; i < NDIGITS; i++) begin
            if (idx == IW'(i)) nxtsel[i] = 1'b0;
         end
         nxtseg = ~hex7(nib);
         nxtdp  = ~curdp;
      end
   end

   // registered pad drivers; only one idx is ever decoded, so at most one digit is enabled
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         digitsel_n <= '1;
         segments_n <= 7'h7F;
         dp_n       <= 1'b1;
      end else begin
         digitsel_n <= nxtsel;
         segments_n <= nxtseg;
         dp_n       <= nxtdp;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed and randomized self-checking bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Summary line reports comparison and mismatch counts.
module tb_seg7_scan_driver;

   logic        clock;
   logic        resetn;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dpin;
   logic [3:0]  blankmask;
   logic [3:0]  digitsel_n;
   logic [6:0]  segments_n;
   logic        dp_n;
   logic        pending;
   logic        framedone;

   int ncompared;
   int nmismatched;

   // segment table from the display definition, gfedcba, 1 = lit
   logic [6:0] hextab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg7_scan_driver #(.NDIGITS(4), .SCANDIV(4), .BLANKCYC(1)) dut (
      .clock      (clock),
      .resetn     (resetn),
      .load       (load),
      .value      (value),
      .dpin       (dpin),
      .blankmask  (blankmask),
      .digitsel_n (digitsel_n),
      .segments_n (segments_n),
      .dp_n       (dp_n),
      .pending    (pending),
      .framedone  (framedone)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncompared++;
      if (got !== exp) begin
         nmismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // expected outputs for one cycle, given the scan state s (0..15) the outputs reflect
   task automatic expect_slot(input int s, input logic [27:0] segs, input logic [3:0] dps,
                              input logic [3:0] blanks, output logic [3:0] esel,
                              output logic [6:0] eseg, output logic edp);
      int d;
      logic [3:0] one;
      d   = s / 4;
      one = 4'b0001;
      if ((s % 4) == 0 || blanks[d]) begin
         esel = 4'b1111;
         eseg = 7'h7F;
         edp  = 1'b1;
      end else begin
         esel = ~(one << d);
         eseg = segs[d*7 +: 7];
         edp  = ~dps[d];
      end
   endtask

   // checks a whole frame; call on a cycle whose scan state is (idx 0, divcount 0)
   task automatic check_frame(input string tag, input logic [27:0] segs,
                              input logic [3:0] dps, input logic [3:0] blanks);
      logic [3:0] esel;
      logic [6:0] eseg;
      logic       edp;
      for (int k = 1; k <= 16; k++) begin
         tick();
         expect_slot(k - 1, segs, dps, blanks, esel, eseg, edp);
         chk({tag, "_sel"}, 32'(digitsel_n), 32'(esel));
         chk({tag, "_seg"}, 32'(segments_n), 32'(eseg));
         chk({tag, "_dp"}, 32'(dp_n), 32'(edp));
         chk({tag, "_fdone"}, 32'(framedone), 32'(k == 16));
      end
   endtask

   task automatic wait_frame(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (framedone) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      logic [15:0] mstagedval, mshownval, nv;
      logic [3:0]  mstageddp, mshowndp, mstagedbl, mshownbl, ndp, nbl;
      logic        mpend, ld;
      logic [27:0] msegs;
      logic [3:0]  esel;
      logic [6:0]  eseg;
      logic        edp;
      int          s, loads;

      ncompared   = 0;
      nmismatched = 0;
      resetn    = 1'b0;
      load      = 1'b0;
      value     = '0;
      dpin      = '0;
      blankmask = '0;

      // 1: reset values, then zeros shown with framedone every 16 cycles
      tick();
      tick();
      chk("rst_sel", 32'(digitsel_n), 32'hF);
      chk("rst_seg", 32'(segments_n), 32'h7F);
      chk("rst_dp", 32'(dp_n), 32'd1);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_fdone", 32'(framedone), 32'd0);
      tick();
      tick();
      tick();
      resetn = 1'b1;
      check_frame("zero1", {4{7'h40}}, 4'b0000, 4'b0000);
      check_frame("zero2", {4{7'h40}}, 4'b0000, 4'b0000);

      // 2: load 0x1234 mid-frame at idx 2; '4' '3' '2' '1' with dp on digit0
      for (int i = 0; i < 8; i++) tick();
      value = 16'h1234; dpin = 4'b0001; blankmask = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      chk("l1234_pend", 32'(pending), 32'd1);
      wait_frame("l1234_wrap");
      chk("l1234_pend_clr", 32'(pending), 32'd0);
      check_frame("s1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0001, 4'b0000);

      // 3: A staged, B loaded on the wrap edge; A then B
      value = 16'h5678; dpin = 4'b0010; load = 1'b1;
      tick();
      load = 1'b0;
      chk("a_pend", 32'(pending), 32'd1);
      for (int i = 0; i < 14; i++) tick();
      value = 16'h9ABC; dpin = 4'b1000; load = 1'b1;
      tick();
      load = 1'b0;
      chk("ab_fdone", 32'(framedone), 32'd1);
      chk("ab_pend", 32'(pending), 32'd1);
      check_frame("showa", {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0010, 4'b0000);
      chk("b_pend_clr", 32'(pending), 32'd0);
      check_frame("showb", {7'h10, 7'h08, 7'h03, 7'h46}, 4'b1000, 4'b0000);

      // 4: digit3 masked, others show '8'
      value = 16'h8888; dpin = 4'b0000; blankmask = 4'b1000; load = 1'b1;
      tick();
      load = 1'b0;
      wait_frame("mask_wrap");
      chk("mask_pend", 32'(pending), 32'd0);
      check_frame("mask", {4{7'h00}}, 4'b0000, 4'b1000);

      // 5: async reset mid-frame with data pending; zeros afterwards
      value = 16'h1111; dpin = 4'b1111; blankmask = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("pre_sel", 32'(digitsel_n), 32'hD);
      chk("pre_seg", 32'(segments_n), 32'h00);
      chk("pre_pend", 32'(pending), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_sel", 32'(digitsel_n), 32'hF);
      chk("arst_seg", 32'(segments_n), 32'h7F);
      chk("arst_dp", 32'(dp_n), 32'd1);
      chk("arst_pend", 32'(pending), 32'd0);
      tick();
      tick();
      resetn = 1'b1;
      check_frame("post1", {4{7'h40}}, 4'b0000, 4'b0000);
      check_frame("post2", {4{7'h40}}, 4'b0000, 4'b0000);

      // 6: random loads with a frame-commit scoreboard, checked every cycle
      mstagedval = '0; mstageddp = '0; mstagedbl = '0;
      mshownval  = '0; mshowndp  = '0; mshownbl  = '0;
      mpend = 1'b0;
      s     = 0;
      loads = 0;
      while (loads < 1000) begin
         ld = ($urandom_range(0, 2) == 0);
         nv  = 16'($urandom);
         ndp = 4'($urandom);
         nbl = 4'($urandom);
         load = ld;
         if (ld) begin
            value = nv; dpin = ndp; blankmask = nbl;
            loads++;
         end
         tick();
         for (int d = 0; d < 4; d++) msegs[d*7 +: 7] = ~hextab[mshownval[d*4 +: 4]];
         expect_slot(s, msegs, mshowndp, mshownbl, esel, eseg, edp);
         if (s == 15 && mpend) begin
            mshownval = mstagedval; mshowndp = mstageddp; mshownbl = mstagedbl;
            mpend = 1'b0;
         end
         if (ld) begin
            mstagedval = nv; mstageddp = ndp; mstagedbl = nbl;
            mpend = 1'b1;
         end
         s = (s + 1) % 16;
         chk("rnd_onehot", 32'($countones(~digitsel_n) <= 1), 32'd1);
         chk("rnd_sel", 32'(digitsel_n), 32'(esel));
         chk("rnd_seg", 32'(segments_n), 32'(eseg));
         chk("rnd_dp", 32'(dp_n), 32'(edp));
         chk("rnd_fdone", 32'(framedone), 32'(s == 0));
         chk("rnd_pend", 32'(pending), 32'(mpend));
      end
      load = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncompared, nmismatched);
      $finish;
   end

endmodule
